// File: rtl/sipo_loader.sv
// Sequencer that shifts a parallel word MSB-first into a 74164-style SIPO chain,
// then strobes the downstream storage latch. All chain-facing pins are registered.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | ser_n_mr held low for DIV cycles, then done pulse
// ST_IDLE  | waiting for valid (or clr, which wins)
// ST_LOW   | ser_cp low, ser_d settling for DIV cycles
// ST_HIGH  | ser_cp high for DIV cycles; chain shifts on the rise
// ST_LATCH | latch_cp high for DIV cycles, then done pulse
module sipo_loader #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic             cp,
   input  logic             n_mr,
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   output logic             ready,
   input  logic             clr,
   output logic             ser_d,
   output logic             ser_cp,
   output logic             ser_n_mr,
   output logic             latch_cp,
   output logic             done
);

   localparam int              BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [7:0]      CNT_RLD = 8'(DIV - 1);
   localparam logic [BW-1:0]   BIT_TOP = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_LATCH
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             ser_d_q, ser_d_d;
   logic             ser_cp_q, ser_cp_d;
   logic             ser_n_mr_q, ser_n_mr_d;
   logic             latch_cp_q, latch_cp_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shadow_sh;
   logic             cnt_zero;

   always_ff @(posedge cp or negedge n_mr) begin
      if (!n_mr) begin
         state_q    <= ST_CLEAR;
         cnt_q      <= CNT_RLD;
         bit_q      <= '0;
         shadow_q   <= '0;
         ser_d_q    <= 1'b0;
         ser_cp_q   <= 1'b0;
         ser_n_mr_q <= 1'b0;
         latch_cp_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shadow_q   <= shadow_d;
         ser_d_q    <= ser_d_d;
         ser_cp_q   <= ser_cp_d;
         ser_n_mr_q <= ser_n_mr_d;
         latch_cp_q <= latch_cp_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shadow_d   = shadow_q;
      ser_d_d    = ser_d_q;
      ser_cp_d   = ser_cp_q;
      ser_n_mr_d = ser_n_mr_q;
      latch_cp_d = latch_cp_q;
      done_d     = 1'b0;
      cnt_zero   = (cnt_q == 8'd0);
      // The word is consumed from the top, so the next bit is always the new MSB.
      shadow_sh  = shadow_q << 1;

      case (state_q)
         ST_CLEAR: begin
            ser_n_mr_d = 1'b0;
            ser_cp_d   = 1'b0;
            latch_cp_d = 1'b0;
            if (cnt_zero) begin
               state_d    = ST_IDLE;
               ser_n_mr_d = 1'b1;
               done_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_d    = ST_CLEAR;
               cnt_d      = CNT_RLD;
               ser_n_mr_d = 1'b0;
            end else if (valid) begin
               state_d  = ST_LOW;
               cnt_d    = CNT_RLD;
               shadow_d = data;
               bit_d    = BIT_TOP;
               ser_d_d  = data[WIDTH-1];
               ser_cp_d = 1'b0;
            end
         end
         ST_LOW: begin
            if (cnt_zero) begin
               state_d  = ST_HIGH;
               cnt_d    = CNT_RLD;
               ser_cp_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_HIGH: begin
            if (cnt_zero) begin
               cnt_d    = CNT_RLD;
               ser_cp_d = 1'b0;
               if (bit_q != '0) begin
                  state_d  = ST_LOW;
                  bit_d    = bit_q - BW'(1);
                  shadow_d = shadow_sh;
                  ser_d_d  = shadow_sh[WIDTH-1];
               end else begin
                  state_d    = ST_LATCH;
                  latch_cp_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_LATCH: begin
            if (cnt_zero) begin
               state_d    = ST_IDLE;
               latch_cp_d = 1'b0;
               done_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d    = ST_CLEAR;
            cnt_d      = CNT_RLD;
            ser_n_mr_d = 1'b0;
            ser_cp_d   = 1'b0;
            latch_cp_d = 1'b0;
         end
      endcase
   end

   assign ready    = (state_q == ST_IDLE) && !clr;
   assign ser_d    = ser_d_q;
   assign ser_cp   = ser_cp_q;
   assign ser_n_mr = ser_n_mr_q;
   assign latch_cp = latch_cp_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sipo_loader.sv
// Bench for sipo_loader: three instances (W8/D1, W8/D3, W1/D2) driving modelled
// 74164 chains and output latches, checked against timing/value rules.
module tb_sipo_loader;

   logic        cp = 1'b0;
   logic        n_mr = 1'b0;
   logic        valid [3] = '{1'b0, 1'b0, 1'b0};
   logic        clr [3]   = '{1'b0, 1'b0, 1'b0};
   logic [31:0] data [3]  = '{32'd0, 32'd0, 32'd0};
   logic        ready [3];
   logic        ser_d [3];
   logic        ser_cp [3];
   logic        ser_n_mr [3];
   logic        latch_cp [3];
   logic        done [3];

   int total = 0;
   int bad = 0;

   always #5 cp = ~cp;

   sipo_loader #(.WIDTH(8), .DIV(1)) dut_a (
      .cp(cp), .n_mr(n_mr), .data(data[0][7:0]), .valid(valid[0]), .ready(ready[0]),
      .clr(clr[0]), .ser_d(ser_d[0]), .ser_cp(ser_cp[0]), .ser_n_mr(ser_n_mr[0]),
      .latch_cp(latch_cp[0]), .done(done[0]));

   sipo_loader #(.WIDTH(8), .DIV(3)) dut_b (
      .cp(cp), .n_mr(n_mr), .data(data[1][7:0]), .valid(valid[1]), .ready(ready[1]),
      .clr(clr[1]), .ser_d(ser_d[1]), .ser_cp(ser_cp[1]), .ser_n_mr(ser_n_mr[1]),
      .latch_cp(latch_cp[1]), .done(done[1]));

   sipo_loader #(.WIDTH(1), .DIV(2)) dut_c (
      .cp(cp), .n_mr(n_mr), .data(data[2][0:0]), .valid(valid[2]), .ready(ready[2]),
      .clr(clr[2]), .ser_d(ser_d[2]), .ser_cp(ser_cp[2]), .ser_n_mr(ser_n_mr[2]),
      .latch_cp(latch_cp[2]), .done(done[2]));

   function automatic int wof(input int k);
      return (k == 2) ? 1 : 8;
   endfunction

   function automatic int dof(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
   endfunction

   // External-hardware model: chain shifts on ser_cp rise, clears on ser_n_mr low,
   // latch captures chain on latch_cp rise. Sampled at negedge, pins are registered.
   int          cyc = 0;
   logic [31:0] chain [3]      = '{32'd0, 32'd0, 32'd0};
   logic [31:0] q_lat [3]      = '{32'd0, 32'd0, 32'd0};
   int          rises [3]      = '{0, 0, 0};
   int          dones [3]      = '{0, 0, 0};
   int          mr_lows [3]    = '{0, 0, 0};
   int          setup_bad [3]  = '{0, 0, 0};
   int          stable [3]     = '{0, 0, 0};
   int          latch_run [3]  = '{0, 0, 0};
   int          latch_len [3]  = '{0, 0, 0};
   int          latch_gap [3]  = '{0, 0, 0};
   int          last_rise [3]  = '{0, 0, 0};
   logic        prev_cp [3]    = '{1'b0, 1'b0, 1'b0};
   logic        prev_d [3]     = '{1'b0, 1'b0, 1'b0};
   logic        prev_lat [3]   = '{1'b0, 1'b0, 1'b0};
   logic        bit_log [3][256];

   always @(negedge cp) begin
      cyc++;
      for (int g = 0; g < 3; g++) begin
         if (!ser_n_mr[g]) begin
            chain[g] = 32'd0;
            mr_lows[g]++;
         end
         if (ser_cp[g] && !prev_cp[g]) begin
            if (stable[g] < dof(g)) setup_bad[g]++;
            if (ser_n_mr[g]) chain[g] = {chain[g][30:0], ser_d[g]};
            bit_log[g][rises[g] % 256] = ser_d[g];
            rises[g]++;
            last_rise[g] = cyc;
         end
         if (ser_d[g] !== prev_d[g]) stable[g] = 1;
         else if (stable[g] < 1000) stable[g]++;
         if (latch_cp[g]) begin
            if (!prev_lat[g]) begin
               q_lat[g]     = chain[g];
               latch_gap[g] = cyc - last_rise[g];
               latch_run[g] = 0;
            end
            latch_run[g]++;
         end else if (prev_lat[g]) begin
            latch_len[g] = latch_run[g];
         end
         if (done[g]) dones[g]++;
         prev_cp[g]  = ser_cp[g];
         prev_d[g]   = ser_d[g];
         prev_lat[g] = latch_cp[g];
      end
   end

   task automatic step();
      @(negedge cp);
      #1;
   endtask

   task automatic wait_ready(input int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (ready[k] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL wait_ready[%0d]: ready=%b, expected 1 within 400 cycles", k, ready[k]);
      end
   endtask

   // Returns number of cp rises after the current point until done is seen (0 = timeout).
   task automatic wait_done(input int k, input int limit, output int n);
      n = 0;
      for (int i = 1; i <= limit; i++) begin
         @(posedge cp);
         #1;
         if (done[k] === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_transfer(input int k, input logic [31:0] word);
      int w, d, n, r0, dn0, sb0, exp_lat;
      bit ok;
      logic [31:0] mask, got_bits, exp_bits;
      w = wof(k);
      d = dof(k);
      mask = (32'd1 << w) - 32'd1;
      exp_lat = 2 * w * d + d;
      wait_ready(k, ok);
      if (!ok) return;
      r0 = rises[k]; dn0 = dones[k]; sb0 = setup_bad[k];
      data[k] = word;
      valid[k] = 1'b1;
      @(posedge cp);
      #1;
      valid[k] = 1'b0;
      data[k] = $urandom;
      total++;
      if (ready[k] !== 1'b0) begin
         bad++; $display("FAIL ready_fall[%0d]: ready=%b, expected 0", k, ready[k]);
      end
      wait_done(k, exp_lat + 20, n);
      total++;
      if (n != exp_lat) begin
         bad++; $display("FAIL latency[%0d]: got %0d cycles, expected %0d", k, n, exp_lat);
      end
      total++;
      if (ready[k] !== 1'b1) begin
         bad++; $display("FAIL ready_at_done[%0d]: ready=%b, expected 1", k, ready[k]);
      end
      step();
      total++;
      if (rises[k] - r0 != w) begin
         bad++; $display("FAIL rise_count[%0d]: got %0d, expected %0d", k, rises[k] - r0, w);
      end
      total++;
      if ((q_lat[k] & mask) !== (word & mask)) begin
         bad++; $display("FAIL latched_q[%0d]: got %h, expected %h", k, q_lat[k] & mask, word & mask);
      end
      got_bits = 32'd0;
      exp_bits = 32'd0;
      for (int i = 0; i < w; i++) begin
         got_bits[i] = bit_log[k][(r0 + i) % 256];
         exp_bits[i] = word[w - 1 - i];
      end
      total++;
      if (got_bits !== exp_bits) begin
         bad++; $display("FAIL ser_d_seq[%0d]: got %h, expected %h (bit i = i-th shifted)", k, got_bits, exp_bits);
      end
      total++;
      if (setup_bad[k] != sb0) begin
         bad++; $display("FAIL setup[%0d]: %0d rises with ser_d stable < %0d cycles, expected 0", k, setup_bad[k] - sb0, d);
      end
      total++;
      if (latch_len[k] != d || latch_gap[k] != d) begin
         bad++; $display("FAIL latch_timing[%0d]: len=%0d gap=%0d, expected %0d and %0d", k, latch_len[k], latch_gap[k], d, d);
      end
      total++;
      if (dones[k] - dn0 != 1) begin
         bad++; $display("FAIL done_pulses[%0d]: got %0d, expected 1", k, dones[k] - dn0);
      end
   endtask

   task automatic test_reset();
      n_mr = 1'b0;
      repeat (3) step();
      total++;
      if (ser_n_mr[2] !== 1'b0 || ready[2] !== 1'b0 || ser_cp[2] !== 1'b0 ||
          latch_cp[2] !== 1'b0 || done[2] !== 1'b0 || ser_d[2] !== 1'b0) begin
         bad++; $display("FAIL reset_outputs: mr=%b rdy=%b cp=%b lat=%b done=%b d=%b, expected 0 0 0 0 0 0",
                         ser_n_mr[2], ready[2], ser_cp[2], latch_cp[2], done[2], ser_d[2]);
      end
      n_mr = 1'b1;
      @(posedge cp); #1;
      total++;
      if (ser_n_mr[2] !== 1'b0 || done[2] !== 1'b0) begin
         bad++; $display("FAIL reset_hold: ser_n_mr=%b done=%b, expected 0 0", ser_n_mr[2], done[2]);
      end
      @(posedge cp); #1;
      total++;
      if (ser_n_mr[2] !== 1'b1 || done[2] !== 1'b1 || ready[2] !== 1'b1) begin
         bad++; $display("FAIL reset_release: ser_n_mr=%b done=%b ready=%b, expected 1 1 1", ser_n_mr[2], done[2], ready[2]);
      end
      @(posedge cp); #1;
      total++;
      if (done[2] !== 1'b0) begin
         bad++; $display("FAIL reset_done_width: done=%b, expected 0", done[2]);
      end
      step();
   endtask

   task automatic test_single();
      do_transfer(0, 32'hA5);
      do_transfer(1, 32'h01);
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 5; i++)
            do_transfer(k, $urandom);
   endtask

   task automatic test_priority();
      int r0, n;
      bit ok;
      wait_ready(0, ok);
      if (!ok) return;
      r0 = rises[0];
      clr[0] = 1'b1; valid[0] = 1'b1; data[0] = 32'hFF;
      #1;
      total++;
      if (ready[0] !== 1'b0) begin
         bad++; $display("FAIL prio_ready: ready=%b, expected 0", ready[0]);
      end
      @(posedge cp); #1;
      clr[0] = 1'b0; valid[0] = 1'b0;
      total++;
      if (ser_n_mr[0] !== 1'b0) begin
         bad++; $display("FAIL prio_clear: ser_n_mr=%b, expected 0", ser_n_mr[0]);
      end
      wait_done(0, 20, n);
      total++;
      if (n != dof(0)) begin
         bad++; $display("FAIL prio_clear_len: got %0d cycles, expected %0d", n, dof(0));
      end
      step();
      total++;
      if (rises[0] != r0 || chain[0] !== 32'd0) begin
         bad++; $display("FAIL prio_no_shift: rises=%0d chain=%h, expected 0 and 0", rises[0] - r0, chain[0]);
      end
   endtask

   task automatic test_ignore_during_xfer();
      int m0;
      logic [31:0] w;
      m0 = mr_lows[1];
      w = $urandom;
      fork
         do_transfer(1, w);
         begin
            repeat (20) step();
            clr[1] = 1'b1; valid[1] = 1'b1;
            repeat (3) step();
            clr[1] = 1'b0; valid[1] = 1'b0;
         end
      join
      total++;
      if (mr_lows[1] != m0) begin
         bad++; $display("FAIL clr_ignored: ser_n_mr low %0d cycles, expected 0", mr_lows[1] - m0);
      end
   endtask

   task automatic test_back_to_back();
      int r0, n;
      bit ok;
      wait_ready(0, ok);
      if (!ok) return;
      r0 = rises[0];
      data[0] = 32'hFF; valid[0] = 1'b1;
      @(posedge cp); #1;
      data[0] = 32'h00;
      wait_done(0, 40, n);
      total++;
      if (n != 17 || ready[0] !== 1'b1) begin
         bad++; $display("FAIL b2b_first: latency=%0d ready=%b, expected 17 and 1", n, ready[0]);
      end
      total++;
      if (q_lat[0][7:0] !== 8'hFF) begin
         bad++; $display("FAIL b2b_q_first: got %h, expected ff", q_lat[0][7:0]);
      end
      @(posedge cp); #1;
      valid[0] = 1'b0;
      total++;
      if (ready[0] !== 1'b0 || done[0] !== 1'b0) begin
         bad++; $display("FAIL b2b_accept: ready=%b done=%b, expected 0 0", ready[0], done[0]);
      end
      wait_done(0, 40, n);
      total++;
      if (n != 17) begin
         bad++; $display("FAIL b2b_second: latency=%0d, expected 17", n);
      end
      step();
      total++;
      if (q_lat[0][7:0] !== 8'h00 || rises[0] - r0 != 16) begin
         bad++; $display("FAIL b2b_q_second: q=%h rises=%0d, expected 00 and 16", q_lat[0][7:0], rises[0] - r0);
      end
   endtask

   task automatic test_abort();
      int r0, dn0;
      bit ok;
      wait_ready(0, ok);
      if (!ok) return;
      r0 = rises[0];
      data[0] = 32'h3C; valid[0] = 1'b1;
      @(posedge cp); #1;
      valid[0] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (rises[0] - r0 >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++; $display("FAIL abort_rises: got %0d rises, expected 4", rises[0] - r0);
      end
      dn0 = dones[0];
      n_mr = 1'b0;
      #1;
      total++;
      if (ser_n_mr[0] !== 1'b0 || latch_cp[0] !== 1'b0 || ready[0] !== 1'b0) begin
         bad++; $display("FAIL abort_async: ser_n_mr=%b latch_cp=%b ready=%b, expected 0 0 0", ser_n_mr[0], latch_cp[0], ready[0]);
      end
      repeat (3) step();
      total++;
      if (dones[0] != dn0 || chain[0] !== 32'd0) begin
         bad++; $display("FAIL abort_no_done: done pulses=%0d chain=%h, expected 0 and 0", dones[0] - dn0, chain[0]);
      end
      n_mr = 1'b1;
      do_transfer(0, 32'h3C);
   endtask

   initial begin
      test_reset();
      test_single();
      test_random();
      test_priority();
      test_ignore_during_xfer();
      test_back_to_back();
      test_abort();
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
